fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the instruction memory: owns the PC, drives readAddress, waits a fixed
//  number of cycles, captures the decoded fields (i1..i4, jump) into registers, and
//  presents them to decode with a valid/ready handshake.
//  Sits between instruction_memory and the decode/control unit.
//  Handles sequential advance (PC+2), branch redirect and halt.
// PARAMETERS
//  RESET_PC   16'h0000  PC value after reset; bit 0 is forced to 0
//  MEM_WAIT   1         extra wait cycles before capture; legal range 0..15
//  WAIT_W     4         width of the wait counter; must hold MEM_WAIT
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   begin fetching from the PC (from IDLE or HALTED)
//  halt_req       in   1   stop fetching
//  branch_taken   in   1   redirect the PC to branch_target
//  branch_target  in   16  new PC; bit 0 ignored (treated as 0)
//  instr_ready    in   1   decode accepts the presented instruction
//  mem_i1..mem_i4 in   4   field outputs of instruction_memory
//  mem_jump       in   12  jump field output of instruction_memory
//  readAddress    out  16  address to instruction_memory
//  i1,i2,i3,i4    out  4   captured fields
//  jump           out  12  captured jump field
//  instr_pc       out  16  PC of the presented instruction
//  instr_valid    out  1   fields are valid and stable
//  halted         out  1   1 while in the HALTED state
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-fetch):
//   - state=IDLE, pc=readAddress=instr_pc=RESET_PC
//   - i1..i4=0, jump=0, instr_valid=0, halted=0, wait_cnt=0
//  readAddress always equals pc (registered). PC increments by 2 modulo 2^16,
//  so 16'hFFFE advances to 16'h0000.
//  IDLE:
//   - start=1 -> FETCH, wait_cnt=0
//  FETCH:
//   - wait_cnt increments each cycle; capture happens on the edge where wait_cnt==MEM_WAIT
//   - capture loads i1..i4 and jump from mem_*, sets instr_pc=pc and instr_valid=1, next state HOLD
//   - Latency: the edge that enters FETCH is edge N; capture occurs at edge N+MEM_WAIT+1
//  HOLD:
//   - outputs are held stable while instr_ready=0
//   - on instr_ready=1: instr_valid<=0; pc<=pc+2, or branch_target if branch_taken=1
//     in the same cycle; next state FETCH, or HALTED if halt_req=1
//  Priority in every state: reset > branch_taken > halt_req > sequential.
//  branch_taken in FETCH:
//   - abort the fetch: pc<=branch_target, wait_cnt<=0, remain in FETCH; no capture occurs
//  branch_taken in HOLD without instr_ready:
//   - ignored; decode must assert it together with instr_ready
//  halt_req in FETCH:
//   - next state HALTED, fetch discarded, pc unchanged
//  halt_req in HOLD:
//   - honoured only on the handshake, so the pending instruction is never dropped
//  HALTED:
//   - halted=1, instr_valid=0
//   - start=1 -> FETCH from the current pc
//   - branch_taken=1 updates pc only
//  start is ignored outside IDLE and HALTED.
// CONFIGURATION
//  FETCH_STALL_COUNT_EN:
//   - Defined: adds output stall_count [15:0], reset 0. It increments, saturating at
//     16'hFFFF, on every cycle with state==HOLD and instr_ready==0.
//   - Undefined: the port and the counter do not exist; all other behaviour is identical.
// TESTING
//  - Memory [0]=8'hAB, [1]=8'hAA, MEM_WAIT=1, start at cycle 0, instr_ready=1 ->
//    instr_valid rises 2 cycles after FETCH entry; i1=A i2=B i3=A i4=A jump=12'hBAA,
//    instr_pc=0; next readAddress=2.
//  - instr_ready held 0 for 5 cycles -> fields and instr_pc stable, no PC advance;
//    with FETCH_STALL_COUNT_EN, stall_count=5.
//  - Branch with target 16'h0041 during FETCH -> fetch aborted; readAddress=16'h0040;
//    capture MEM_WAIT+1 cycles later with instr_pc=16'h0040.
//  - pc=16'hFFFE, handshake -> readAddress wraps to 16'h0000.
//  - halt_req in HOLD with instr_ready=0 -> stays HOLD; on handshake -> halted=1,
//    instr_valid=0; start -> resumes at pc+2.
//  - reset asserted mid-FETCH (asynchronously, between edges) -> all outputs return to
//    reset values immediately; IDLE until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, waits MEM_WAIT cycles on instruction_memory,
// captures the decoded fields and presents them to decode with valid/ready. Option: FETCH_STALL_COUNT_EN.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        instr_ready,
   input  logic [3:0]  mem_i1,
   input  logic [3:0]  mem_i2,
   input  logic [3:0]  mem_i3,
   input  logic [3:0]  mem_i4,
   input  logic [11:0] mem_jump,
   output logic [15:0] readAddress,
   output logic [3:0]  i1,
   output logic [3:0]  i2,
   output logic [3:0]  i3,
   output logic [3:0]  i4,
   output logic [11:0] jump,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   output logic        halted
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [15:0]       RESET_PC_C = {RESET_PC[15:1], 1'b0};
   localparam logic [WAIT_W-1:0] MEM_WAIT_C = WAIT_W'(MEM_WAIT);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [15:0]       pc_r;
   logic [15:0]       pc_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_nxt_s;
   logic              capture_s;
   logic              valid_nxt_s;
   logic [15:0]       branch_pc_s;
   logic [15:0]       pc_inc_s;
   logic [3:0]        i1_r, i2_r, i3_r, i4_r;
   logic [11:0]       jump_r;
   logic [15:0]       instr_pc_r;
   logic              valid_r;
   logic              halted_r;

   assign branch_pc_s = {branch_target[15:1], 1'b0};
   assign pc_inc_s    = pc_r + 16'd2;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, PC, wait counter and capture decisions; branch beats halt beats sequential
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      wait_nxt_s  = wait_cnt_r;
      capture_s   = 1'b0;
      valid_nxt_s = valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_FETCH;
               wait_nxt_s  = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (branch_taken) begin
               pc_nxt_s   = branch_pc_s;
               wait_nxt_s = '0;
            end else if (halt_req) begin
               state_nxt_s = ST_HALTED;
               wait_nxt_s  = '0;
            end else if (wait_cnt_r == MEM_WAIT_C) begin
               capture_s   = 1'b1;
               valid_nxt_s = 1'b1;
               state_nxt_s = ST_HOLD;
               wait_nxt_s  = '0;
            end else begin
               wait_nxt_s = wait_cnt_r + WAIT_W'(1);
            end
         end
         ST_HOLD: begin
            // Branch and halt only act on the handshake so the presented instruction is never lost
            if (instr_ready) begin
               valid_nxt_s = 1'b0;
               wait_nxt_s  = '0;
               pc_nxt_s    = branch_taken ? branch_pc_s : pc_inc_s;
               state_nxt_s = halt_req ? ST_HALTED : ST_FETCH;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_HALTED: begin
            if (branch_taken) begin
               pc_nxt_s = branch_pc_s;
            end else if (start) begin
               state_nxt_s = ST_FETCH;
               wait_nxt_s  = '0;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            wait_nxt_s  = '0;
         end
      endcase
   end

   // Datapath registers: PC, wait counter, captured fields and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r       <= RESET_PC_C;
         wait_cnt_r <= '0;
         i1_r       <= 4'd0;
         i2_r       <= 4'd0;
         i3_r       <= 4'd0;
         i4_r       <= 4'd0;
         jump_r     <= 12'd0;
         instr_pc_r <= RESET_PC_C;
         valid_r    <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         pc_r       <= pc_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         valid_r    <= valid_nxt_s;
         halted_r   <= (state_nxt_s == ST_HALTED);
         if (capture_s) begin
            i1_r       <= mem_i1;
            i2_r       <= mem_i2;
            i3_r       <= mem_i3;
            i4_r       <= mem_i4;
            jump_r     <= mem_jump;
            instr_pc_r <= pc_r;
         end
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   logic [15:0] stall_count_r;

   // Saturating count of cycles decode spends refusing a presented instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_r <= 16'd0;
      end else if ((state_r == ST_HOLD) && !instr_ready && (stall_count_r != 16'hFFFF)) begin
         stall_count_r <= stall_count_r + 16'd1;
      end
   end

   assign stall_count = stall_count_r;
`endif

   assign readAddress = pc_r;
   assign i1          = i1_r;
   assign i2          = i2_r;
   assign i3          = i3_r;
   assign i4          = i4_r;
   assign jump        = jump_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = valid_r;
   assign halted      = halted_r;

endmodule
